mem_arbiter_rr: RTL

//  N-client round-robin arbiter between cache clients (icache, dcache, future prefetcher/PTW) and the memory controller.

---
 rtl/mem_arbiter_rr_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_picker.sv | 29 ++
 rtl/mem_arbiter_rr.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        RELEASE
    } arb_state_e;

    localparam int DEFAULT_ADDR_W = 64;
    localparam int DEFAULT_LINE_W = 512;

    // Position 'off' steps after 'base' on a ring of n slots (base, off < n).
    function automatic int ring_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!any && req[ring_idx(int'(ptr), off, N)]) begin
                grant[ring_idx(int'(ptr), off, N)] = 1'b1;
                idx = IDX_W'(ring_idx(int'(ptr), off, N));
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of N cache clients onto one memory request channel,
// plus a registered invalidation-snoop fan-out to the clients in INV_MASK.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int LINE_W      = DEFAULT_LINE_W,
    parameter logic [NUM_CLIENTS-1:0] INV_MASK = 'b10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        cli_req,
    input  logic [NUM_CLIENTS-1:0]        cli_wr_en,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLIENTS*LINE_W-1:0] cli_wdata,
    output logic [LINE_W-1:0]             cli_rdata,
    output logic [NUM_CLIENTS-1:0]        cli_done,
    output logic [NUM_CLIENTS-1:0]        cli_inv,
    output logic [ADDR_W-1:0]             cli_inv_addr,
    output logic                          mem_req,
    output logic                          mem_wr_en,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [LINE_W-1:0]             mem_data_out,
    input  logic [LINE_W-1:0]             data_from_mem,
    input  logic                          mem_data_valid,
    input  logic                          invalidate_cache,
    input  logic [ADDR_W-1:0]             invalidate_cache_addr
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    arb_state_e             state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       cur_id;
    logic [NUM_CLIENTS-1:0] cur_grant;
    logic                   aborted;

    logic [NUM_CLIENTS-1:0] pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   held;

    rr_picker #(.N(NUM_CLIENTS)) u_picker (
        .req   (cli_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign held = |(cli_req & cur_grant);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cur_id       <= '0;
            cur_grant    <= '0;
            aborted      <= 1'b0;
            mem_req      <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_address  <= '0;
            mem_data_out <= '0;
            cli_done     <= '0;
            cli_rdata    <= '0;
        end else begin
            mem_req  <= 1'b0;
            cli_done <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        cur_id       <= pick_idx;
                        cur_grant    <= pick_grant;
                        aborted      <= 1'b0;
                        mem_address  <= cli_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        mem_data_out <= cli_wdata[int'(pick_idx)*LINE_W +: LINE_W];
                        mem_wr_en    <= cli_wr_en[pick_idx];
                        mem_req      <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    // An aborted transaction still drains the memory reply, silently.
                    if (mem_data_valid) begin
                        cli_rdata <= data_from_mem;
                        mem_wr_en <= 1'b0;
                        cli_done  <= (aborted || !held) ? '0 : cur_grant;
                        state     <= DONE;
                    end else begin
                        if (!held) aborted <= 1'b1;
                        state <= WAIT;
                    end
                end
                DONE: begin
                    rr_ptr <= (cur_id == IDX_W'(NUM_CLIENTS - 1)) ? '0 : cur_id + 1'b1;
                    state  <= RELEASE;
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cli_inv      <= '0;
            cli_inv_addr <= '0;
        end else begin
            cli_inv      <= {NUM_CLIENTS{invalidate_cache}} & INV_MASK;
            cli_inv_addr <= invalidate_cache_addr;
        end
    end

endmodule
